// File: rtl/fp16_pkg.sv
// Shared FP16 field layout, class encodings and loader state encoding.
package fp16_pkg;

  localparam int FP16_W   = 16;
  localparam int BYTE_W   = 8;
  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 10;
  localparam int EXP_W    = 5;
  localparam int MANT_MSB = 9;
  localparam int MANT_W   = 10;
  localparam int CLASS_W  = 3;

  typedef logic [CLASS_W-1:0] fp_class_t;

  localparam fp_class_t CLS_ZERO = 3'd0;
  localparam fp_class_t CLS_SUB  = 3'd1;
  localparam fp_class_t CLS_NORM = 3'd2;
  localparam fp_class_t CLS_INF  = 3'd3;
  localparam fp_class_t CLS_NAN  = 3'd4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_HI = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

endpackage

// File: rtl/fp16_operand_loader_if.sv
// Byte-in / operand-pair-out bus of the FP16 operand loader.
interface fp16_operand_loader_if;
  import fp16_pkg::*;

  logic              byte_valid;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic              in_ready;
  logic [FP16_W-1:0] op_a;
  logic [FP16_W-1:0] op_b;
  fp_class_t         a_class;
  fp_class_t         b_class;
  logic              out_valid;
  logic              out_ready;
  logic              drop;
  logic [7:0]        drop_cnt;

  modport master (
    output byte_valid, a_byte, b_byte, out_ready,
    input  in_ready, op_a, op_b, a_class, b_class, out_valid, drop, drop_cnt
  );

  modport slave (
    input  byte_valid, a_byte, b_byte, out_ready,
    output in_ready, op_a, op_b, a_class, b_class, out_valid, drop, drop_cnt
  );

endinterface

// File: rtl/fp16_classify.sv
// Combinational FP16 classifier: zero, subnormal, normal, infinity or NaN.
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [FP16_W-1:0] value,
  output fp_class_t         fp_class
);

  logic [EXP_W-1:0]  exp_s;
  logic [MANT_W-1:0] mant_s;
  logic              unused_sign_s;

  assign exp_s         = value[EXP_MSB:EXP_LSB];
  assign mant_s        = value[MANT_MSB:0];
  assign unused_sign_s = value[SIGN_BIT];

  // Class decode from exponent and mantissa fields
  always_comb begin
    fp_class = CLS_NORM;
    if (exp_s == {EXP_W{1'b0}}) begin
      if (mant_s == {MANT_W{1'b0}}) begin
        fp_class = CLS_ZERO;
      end else begin
        fp_class = CLS_SUB;
      end
    end else if (exp_s == {EXP_W{1'b1}}) begin
      if (mant_s == {MANT_W{1'b0}}) begin
        fp_class = CLS_INF;
      end else begin
        fp_class = CLS_NAN;
      end
    end else begin
      fp_class = CLS_NORM;
    end
  end

endmodule

// File: rtl/fp16_operand_loader.sv
// Assembles FP16 operand pairs from low/high byte streams, classifies them and
// holds the pair for the multiplier; stalled half-pairs are dropped on timeout.
module fp16_operand_loader
  import fp16_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
)
(
  input logic                  clk,
  input logic                  rst,
  fp16_operand_loader_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_r;
  logic [BYTE_W-1:0] lo_a_r;
  logic [BYTE_W-1:0] lo_b_r;
  logic [CNT_W-1:0]  tmo_cnt_r;
  logic [FP16_W-1:0] op_a_r;
  logic [FP16_W-1:0] op_b_r;
  fp_class_t         a_class_r;
  fp_class_t         b_class_r;
  logic              out_valid_r;
  logic              drop_r;
  logic [7:0]        drop_cnt_r;

  logic              in_ready_s;
  logic              accept_s;
  logic [FP16_W-1:0] word_a_s;
  logic [FP16_W-1:0] word_b_s;
  fp_class_t         a_class_s;
  fp_class_t         b_class_s;

  // Upstream may only push while no pair is pending, or as the pending pair leaves
  always_comb begin
    case (state_r)
      ST_IDLE:    in_ready_s = 1'b1;
      ST_WAIT_HI: in_ready_s = 1'b1;
      ST_HOLD:    in_ready_s = bus.out_ready;
      default:    in_ready_s = 1'b1;
    endcase
  end

  assign accept_s = bus.byte_valid & in_ready_s;
  assign word_a_s = {bus.a_byte, lo_a_r};
  assign word_b_s = {bus.b_byte, lo_b_r};

  // Classify the word being completed so class is captured with the operand
  fp16_classify u_class_a (.value(word_a_s), .fp_class(a_class_s));
  fp16_classify u_class_b (.value(word_b_s), .fp_class(b_class_s));

  // Pair assembly FSM, output registers and timeout/drop bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      lo_a_r      <= 8'h00;
      lo_b_r      <= 8'h00;
      tmo_cnt_r   <= '0;
      op_a_r      <= 16'h0000;
      op_b_r      <= 16'h0000;
      a_class_r   <= CLS_ZERO;
      b_class_r   <= CLS_ZERO;
      out_valid_r <= 1'b0;
      drop_r      <= 1'b0;
      drop_cnt_r  <= 8'h00;
    end else begin
      drop_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            lo_a_r    <= bus.a_byte;
            lo_b_r    <= bus.b_byte;
            tmo_cnt_r <= '0;
            state_r   <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          // A high byte arriving on the expiry cycle wins over the timeout
          if (accept_s) begin
            op_a_r      <= word_a_s;
            op_b_r      <= word_b_s;
            a_class_r   <= a_class_s;
            b_class_r   <= b_class_s;
            out_valid_r <= 1'b1;
            state_r     <= ST_HOLD;
          end else if (tmo_cnt_r == TMO_LAST) begin
            drop_r  <= 1'b1;
            state_r <= ST_IDLE;
            if (drop_cnt_r != 8'hFF) begin
              drop_cnt_r <= drop_cnt_r + 8'd1;
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (accept_s) begin
              lo_a_r    <= bus.a_byte;
              lo_b_r    <= bus.b_byte;
              tmo_cnt_r <= '0;
              state_r   <= ST_WAIT_HI;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.op_a      = op_a_r;
  assign bus.op_b      = op_b_r;
  assign bus.a_class   = a_class_r;
  assign bus.b_class   = b_class_r;
  assign bus.out_valid = out_valid_r;
  assign bus.drop      = drop_r;
  assign bus.drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_fp16_operand_loader.sv
// Directed self-checking bench for fp16_operand_loader.
module tb_fp16_operand_loader;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fp16_operand_loader_if bus_if ();

  fp16_operand_loader #(.TIMEOUT_CYCLES(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, let one rising edge pass, return 1 time unit after it.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic r);
    bus_if.byte_valid = v;
    bus_if.a_byte     = a;
    bus_if.b_byte     = b;
    bus_if.out_ready  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 8'h00, 8'h3C, 1'b0);
    step(1'b1, 8'h3C, 8'h00, 1'b0);
    checks++;
    if ({bus_if.out_valid, bus_if.op_a, bus_if.op_b} !== {1'b1, 16'h3C00, 16'h003C}) begin
      errors++;
      $display("FAIL reset_preload got v=%0b a=%h b=%h want v=1 a=3c00 b=003c",
               bus_if.out_valid, bus_if.op_a, bus_if.op_b);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_if.in_ready, bus_if.out_valid, bus_if.op_a, bus_if.op_b, bus_if.a_class,
         bus_if.b_class, bus_if.drop, bus_if.drop_cnt} !== {1'b1, 1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset_async got rdy=%0b v=%0b a=%h b=%h ac=%0d bc=%0d drop=%0b cnt=%0d want rdy=1 rest 0",
               bus_if.in_ready, bus_if.out_valid, bus_if.op_a, bus_if.op_b, bus_if.a_class,
               bus_if.b_class, bus_if.drop, bus_if.drop_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 8'h00, 8'h00, 1'b1);
    checks++;
    if ({bus_if.out_valid, bus_if.drop} !== 2'b00) begin
      errors++;
      $display("FAIL reset_after got v=%0b drop=%0b want 0 0", bus_if.out_valid, bus_if.drop);
    end
  endtask

  task automatic test_normal();
    step(1'b1, 8'h00, 8'h00, 1'b1);
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL normal_lo_valid got %0b want 0", bus_if.out_valid);
    end
    step(1'b1, 8'h3E, 8'h42, 1'b1);
    checks++;
    if ({bus_if.out_valid, bus_if.op_a, bus_if.op_b, bus_if.a_class, bus_if.b_class} !==
        {1'b1, 16'h3E00, 16'h4200, 3'd2, 3'd2}) begin
      errors++;
      $display("FAIL normal_pair got v=%0b a=%h b=%h ac=%0d bc=%0d want v=1 a=3e00 b=4200 ac=2 bc=2",
               bus_if.out_valid, bus_if.op_a, bus_if.op_b, bus_if.a_class, bus_if.b_class);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1);
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL normal_taken got %0b want 0", bus_if.out_valid);
    end
  endtask

  task automatic test_special();
    step(1'b1, 8'h00, 8'h01, 1'b1);
    step(1'b1, 8'h7C, 8'h7E, 1'b1);
    checks++;
    if ({bus_if.out_valid, bus_if.op_a, bus_if.op_b, bus_if.a_class, bus_if.b_class} !==
        {1'b1, 16'h7C00, 16'h7E01, 3'd3, 3'd4}) begin
      errors++;
      $display("FAIL special_inf_nan got v=%0b a=%h b=%h ac=%0d bc=%0d want v=1 a=7c00 b=7e01 ac=3 bc=4",
               bus_if.out_valid, bus_if.op_a, bus_if.op_b, bus_if.a_class, bus_if.b_class);
    end
    // Next low byte accepted in the same cycle the held pair is taken
    step(1'b1, 8'h01, 8'h00, 1'b1);
    checks++;
    if ({bus_if.out_valid, bus_if.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL special_b2b_lo got v=%0b rdy=%0b want v=0 rdy=1", bus_if.out_valid, bus_if.in_ready);
    end
    step(1'b1, 8'h00, 8'h00, 1'b1);
    checks++;
    if ({bus_if.out_valid, bus_if.op_a, bus_if.op_b, bus_if.a_class, bus_if.b_class} !==
        {1'b1, 16'h0001, 16'h0000, 3'd1, 3'd0}) begin
      errors++;
      $display("FAIL special_sub_zero got v=%0b a=%h b=%h ac=%0d bc=%0d want v=1 a=0001 b=0000 ac=1 bc=0",
               bus_if.out_valid, bus_if.op_a, bus_if.op_b, bus_if.a_class, bus_if.b_class);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_back_pressure();
    step(1'b1, 8'h34, 8'h12, 1'b0);
    step(1'b1, 8'hBC, 8'hAB, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h55, 8'h66, 1'b0);
      checks++;
      if ({bus_if.out_valid, bus_if.in_ready, bus_if.op_a, bus_if.op_b, bus_if.a_class, bus_if.b_class} !==
          {1'b1, 1'b0, 16'hBC34, 16'hAB12, 3'd2, 3'd2}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%0b rdy=%0b a=%h b=%h ac=%0d bc=%0d want v=1 rdy=0 a=bc34 b=ab12 ac=2 bc=2",
                 i, bus_if.out_valid, bus_if.in_ready, bus_if.op_a, bus_if.op_b, bus_if.a_class, bus_if.b_class);
      end
    end
    step(1'b1, 8'h55, 8'h66, 1'b1);
    checks++;
    if ({bus_if.out_valid, bus_if.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got v=%0b rdy=%0b want v=0 rdy=1", bus_if.out_valid, bus_if.in_ready);
    end
    step(1'b1, 8'hC0, 8'hC0, 1'b1);
    checks++;
    if ({bus_if.out_valid, bus_if.op_a, bus_if.op_b} !== {1'b1, 16'hC055, 16'hC066}) begin
      errors++;
      $display("FAIL bp_next_pair got v=%0b a=%h b=%h want v=1 a=c055 b=c066",
               bus_if.out_valid, bus_if.op_a, bus_if.op_b);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_mid_reset();
    step(1'b1, 8'h12, 8'h34, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_if.out_valid, bus_if.drop, bus_if.drop_cnt, bus_if.in_ready} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL midrst_async got v=%0b drop=%0b cnt=%0d rdy=%0b want 0 0 0 1",
               bus_if.out_valid, bus_if.drop, bus_if.drop_cnt, bus_if.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h56, 8'h78, 1'b1);
    checks++;
    if ({bus_if.out_valid, bus_if.drop, bus_if.drop_cnt} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL midrst_idle got v=%0b drop=%0b cnt=%0d want 0 0 0",
               bus_if.out_valid, bus_if.drop, bus_if.drop_cnt);
    end
    step(1'b1, 8'h9A, 8'hBC, 1'b1);
    checks++;
    if ({bus_if.out_valid, bus_if.op_a, bus_if.op_b, bus_if.drop_cnt} !== {1'b1, 16'h9A56, 16'hBC78, 8'h00}) begin
      errors++;
      $display("FAIL midrst_pair got v=%0b a=%h b=%h cnt=%0d want v=1 a=9a56 b=bc78 cnt=0",
               bus_if.out_valid, bus_if.op_a, bus_if.op_b, bus_if.drop_cnt);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_timeout();
    step(1'b1, 8'h11, 8'h22, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b1);
      checks++;
      if ({bus_if.drop, bus_if.out_valid, bus_if.drop_cnt} !== {1'b0, 1'b0, 8'h00}) begin
        errors++;
        $display("FAIL tmo_idle[%0d] got drop=%0b v=%0b cnt=%0d want 0 0 0",
                 i, bus_if.drop, bus_if.out_valid, bus_if.drop_cnt);
      end
    end
    step(1'b0, 8'h00, 8'h00, 1'b1);
    checks++;
    if ({bus_if.drop, bus_if.drop_cnt} !== {1'b1, 8'h01}) begin
      errors++;
      $display("FAIL tmo_drop got drop=%0b cnt=%0d want 1 1", bus_if.drop, bus_if.drop_cnt);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1);
    checks++;
    if ({bus_if.drop, bus_if.drop_cnt} !== {1'b0, 8'h01}) begin
      errors++;
      $display("FAIL tmo_pulse got drop=%0b cnt=%0d want 0 1", bus_if.drop, bus_if.drop_cnt);
    end
    // Back in IDLE: the stale low bytes must not join the next pair
    step(1'b1, 8'h00, 8'h00, 1'b1);
    step(1'b1, 8'h3C, 8'h3C, 1'b1);
    checks++;
    if ({bus_if.out_valid, bus_if.op_a, bus_if.op_b} !== {1'b1, 16'h3C00, 16'h3C00}) begin
      errors++;
      $display("FAIL tmo_idle_pair got v=%0b a=%h b=%h want v=1 a=3c00 b=3c00",
               bus_if.out_valid, bus_if.op_a, bus_if.op_b);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1);
    // High byte on the expiry cycle wins
    step(1'b1, 8'hAA, 8'hBB, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b1);
    end
    step(1'b1, 8'h3C, 8'h40, 1'b1);
    checks++;
    if ({bus_if.out_valid, bus_if.drop, bus_if.drop_cnt, bus_if.op_a, bus_if.op_b} !==
        {1'b1, 1'b0, 8'h01, 16'h3CAA, 16'h40BB}) begin
      errors++;
      $display("FAIL tmo_priority got v=%0b drop=%0b cnt=%0d a=%h b=%h want v=1 drop=0 cnt=1 a=3caa b=40bb",
               bus_if.out_valid, bus_if.drop, bus_if.drop_cnt, bus_if.op_a, bus_if.op_b);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1);
    checks++;
    if ({bus_if.drop, bus_if.drop_cnt, bus_if.out_valid} !== {1'b0, 8'h01, 1'b0}) begin
      errors++;
      $display("FAIL tmo_priority_after got drop=%0b cnt=%0d v=%0b want 0 1 0",
               bus_if.drop, bus_if.drop_cnt, bus_if.out_valid);
    end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst               = 1'b1;
    bus_if.byte_valid = 1'b0;
    bus_if.a_byte     = 8'h00;
    bus_if.b_byte     = 8'h00;
    bus_if.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_normal();
    test_special();
    test_back_pressure();
    test_mid_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
